// File: rtl/div_job_sequencer.sv
// div_job_sequencer: buffers dividend/divisor jobs in a small FIFO and launches
// them one at a time on the divider control unit. It follows Busy, captures the
// quotient from datapath reg0 and holds it on a valid/ready result port.
module div_job_sequencer #(
  parameter int DATA_W        = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_dividend,
  input  logic [DATA_W-1:0]             in_divisor,
  output logic [DATA_W-1:0]             inA,
  output logic [DATA_W-1:0]             inB,
  output logic                          Start,
  input  logic                          Busy,
  input  logic [DATA_W-1:0]             result_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_quotient,
  output logic                          out_dbz,
  output logic                          out_err,
  output logic [$clog2(FIFO_DEPTH):0]   jobs_pending
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_SETTLE    = 3'd4;
  localparam logic [2:0] S_RESULT    = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0] n;
    logic [DATA_W-1:0] d;
  } job_t;

  job_t            mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            in_ready_q;
  logic [2:0]      state_q, state_d;
  logic [TW-1:0]   tmr_q;
  logic            start_q, dbz_q;
  logic [DATA_W-1:0] inA_q, inB_q, quot_q;
  logic            out_valid_q, out_dbz_q, out_err_q;

  logic push, pop, launch_go, timeout, capture;
  job_t head;

  assign head      = mem_q[rd_ptr_q];
  assign push      = in_valid && in_ready_q;
  // The head entry is consumed at the end of the LAUNCH cycle.
  assign pop       = (state_q == S_LAUNCH);
  assign launch_go = (state_q == S_IDLE) && (count_q != '0) && !out_valid_q && !Busy;
  // A Busy arriving on the last waiting cycle still counts as a good start.
  assign timeout   = (state_q == S_WAIT_BUSY) && !Busy && (tmr_q == TW'(START_TIMEOUT - 1));
  assign capture   = (state_q == S_SETTLE) || timeout;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  // FIFO storage: written on every accepted job, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{n: in_dividend, d: in_divisor};
  end

  // FIFO pointers, occupancy and registered ready (never bypasses a pop).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d != CW'(FIFO_DEPTH));
    end
  end

  // Next-state logic for the single-job-in-flight sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (launch_go) state_d = S_LAUNCH;
      S_LAUNCH:    state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (Busy) state_d = S_WAIT_DONE;
                   else if (timeout) state_d = S_RESULT;
      S_WAIT_DONE: if (!Busy) state_d = S_SETTLE;
      S_SETTLE:    state_d = S_RESULT;
      S_RESULT:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State, start pulse, operand registers and start-timeout counter.
  // Operands and Start are loaded on entry to LAUNCH so the control unit
  // sees stable operands in the same cycle as the pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      inA_q   <= '0;
      inB_q   <= '0;
      dbz_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= launch_go;
      if (launch_go) begin
        inA_q <= head.n;
        inB_q <= head.d;
        dbz_q <= (head.d == '0);
      end
      if (state_q == S_LAUNCH)         tmr_q <= '0;
      else if (state_q == S_WAIT_BUSY) tmr_q <= tmr_q + 1'b1;
    end
  end

  // Result holding register: captured once per job, cleared on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      out_dbz_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      quot_q      <= timeout ? '0 : result_in;
      out_dbz_q   <= dbz_q;
      out_err_q   <= timeout;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      out_dbz_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end
  end

  assign in_ready     = in_ready_q;
  assign inA          = inA_q;
  assign inB          = inB_q;
  assign Start        = start_q;
  assign out_valid    = out_valid_q;
  assign out_quotient = quot_q;
  assign out_dbz      = out_dbz_q;
  assign out_err      = out_err_q;
  assign jobs_pending = count_q;
endmodule

// File: tb/tb_div_job_sequencer.sv
// Bench for div_job_sequencer: a behavioural control-unit/datapath model
// answers Start pulses, a scoreboard queue holds the expected results in
// job order, and a negedge monitor checks results, stability and pulses.
module tb_div_job_sequencer;
  logic       clk = 0, reset = 1;
  logic       in_valid = 0, in_ready;
  logic [7:0] in_dividend = 0, in_divisor = 0;
  logic [7:0] inA, inB, result_in;
  logic       Start, Busy;
  logic       out_valid, out_ready = 1;
  logic [7:0] out_quotient;
  logic       out_dbz, out_err;
  logic [2:0] jobs_pending;

  div_job_sequencer #(.DATA_W(8), .FIFO_DEPTH(4), .START_TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .inA(inA), .inB(inB),
    .Start(Start), .Busy(Busy), .result_in(result_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_quotient(out_quotient), .out_dbz(out_dbz),
    .out_err(out_err), .jobs_pending(jobs_pending));

  always #5 clk = ~clk;

  typedef struct { logic [7:0] q; logic dbz; logic err; } exp_t;
  exp_t sb[$];

  int checks = 0, errors = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, fall_cyc = 0, pk = 0;
  logic m_no_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control unit + datapath model: Busy one cycle after Start, five busy
  // cycles, quotient written to reg0 as Busy falls (0 for a zero divisor).
  initial begin
    logic [7:0] a, b;
    Busy = 0; result_in = 0;
    forever begin
      @(posedge clk); #1;
      if (Start && !m_no_busy && !reset) begin
        a = inA; b = inB; result_in = 8'hEE;
        @(posedge clk); #1; Busy = 1;
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          if (reset) break;
          chk("hold_inA", inA, a);
          chk("hold_inB", inB, b);
        end
        if (!reset) result_in = (b == 0) ? 8'h00 : a / b;
        Busy = 0;
      end else if (Start) begin
        result_in = 8'hEE;
      end
    end
  end

  // Monitor: scoreboard pops, hold stability, Start rules, latencies.
  initial begin
    logic prev_ov, prev_ordy, prev_start, prev_busy, pd, pe;
    logic [7:0] pq;
    exp_t e;
    prev_ov = 0; prev_ordy = 0; prev_start = 0; prev_busy = 0; pq = 0; pd = 0; pe = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_ov = 0; prev_start = 0; prev_busy = 0;
      end else begin
        if (int'(jobs_pending) > pk) pk = int'(jobs_pending);
        if (Start) begin
          start_cnt++; start_cyc = cyc;
          chk("start_while_busy", Busy, 0);
          chk("start_twice", prev_start, 0);
        end
        if (prev_busy && !Busy) fall_cyc = cyc;
        if (out_valid && !prev_ov) begin
          if (m_no_busy) chk("timeout_latency", cyc - start_cyc, 9);
          else           chk("busy_fall_latency", cyc - fall_cyc, 2);
        end
        if (prev_ov && !prev_ordy) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_quot", out_quotient, pq);
          chk("hold_dbz", out_dbz, pd);
          chk("hold_err", out_err, pe);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("unexpected_result", 1, 0);
          else begin
            e = sb.pop_front();
            chk("quotient", out_quotient, e.q);
            chk("dbz", out_dbz, e.dbz);
            chk("err", out_err, e.err);
          end
        end
        prev_ov = out_valid; prev_ordy = out_ready; prev_start = Start;
        prev_busy = Busy; pq = out_quotient; pd = out_dbz; pe = out_err;
      end
    end
  end

  task automatic push(input logic [7:0] n, d, q, input logic dz, er);
    int t = 0;
    in_valid = 1; in_dividend = n; in_divisor = d;
    @(negedge clk);
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    chk("push_accepted", in_ready, 1);
    sb.push_back('{q, dz, er});
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || out_valid) && t < 600) begin @(posedge clk); #1; t++; end
    chk("drain_done", sb.size(), 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_Start"}, Start, 0);
    chk({tag, "_inA"}, inA, 0);
    chk({tag, "_inB"}, inB, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_quot"}, out_quotient, 0);
    chk({tag, "_dbz"}, out_dbz, 0);
    chk({tag, "_err"}, out_err, 0);
    chk({tag, "_pending"}, jobs_pending, 0);
  endtask

  initial begin
    int t, s0;
    // Reset values, then ready one cycle after release.
    #12; reset_vals("rst");
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Basic divide and divide-by-zero.
    push(8'd20, 8'd6, 8'd3, 0, 0);
    drain();
    chk("one_start", start_cnt, 1);
    push(8'd9, 8'd0, 8'd0, 1, 0);
    drain();

    // Hold the first result for 20 cycles while the FIFO fills behind it.
    out_ready = 0;
    push(8'd100, 8'd7, 8'd14, 0, 0);
    t = 0;
    while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
    chk("held_result_valid", out_valid, 1);
    s0 = start_cnt;
    push(8'd30, 8'd3, 8'd10, 0, 0);
    push(8'd255, 8'd16, 8'd15, 0, 0);
    push(8'd8, 8'd9, 8'd0, 0, 0);
    push(8'd77, 8'd1, 8'd77, 0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("no_start_while_held", start_cnt, s0);
    chk("full_pending", jobs_pending, 4);
    chk("full_in_ready", in_ready, 0);
    out_ready = 1;
    push(8'd200, 8'd9, 8'd22, 0, 0);
    drain();
    chk("pending_peak", pk, 4);

    // Busy never rises: timeout result, then the next job runs normally.
    m_no_busy = 1;
    push(8'd7, 8'd2, 8'd0, 0, 1);
    drain();
    m_no_busy = 0;
    push(8'd50, 8'd5, 8'd10, 0, 0);
    drain();

    // Reset during WAIT_DONE with two jobs queued.
    push(8'd40, 8'd4, 8'd10, 0, 0);
    push(8'd60, 8'd6, 8'd10, 0, 0);
    push(8'd1, 8'd1, 8'd1, 0, 0);
    t = 0;
    while (!Busy && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk);
    @(negedge clk);
    chk("queued_before_reset", jobs_pending, 2);
    reset = 1; #1;
    sb.delete();
    reset_vals("midjob_rst");
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(posedge clk); #1;
    chk("in_ready_after_midjob_reset", in_ready, 1);
    s0 = start_cnt;
    repeat (10) @(posedge clk);
    #1;
    chk("no_start_after_flush", start_cnt, s0);
    chk("empty_after_flush", jobs_pending, 0);
    push(8'd15, 8'd4, 8'd3, 0, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
